// File: rtl/mcu51_bus_pkg.sv
// Shared definitions for the 8051-style external program-fetch bus.
// Used by the fetch responder and by the CU side of the bus.
package mcu51_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

  localparam int PX_OE  = 3;
  localparam int PX_EN  = 2;
  localparam int PX_SRC = 1;
  localparam int PX_RE  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOOKUP,
    ST_READY,
    ST_DRIVE
  } bus_state_e;

endpackage

// File: rtl/bus_edge_det.sv
// Registered rise/fall detector for a bus strobe.
// INIT is the idle level of the strobe held across reset.
module bus_edge_det #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= INIT;
    else       sig_q <= sig;
  end

  assign rise = ~sig_q & sig;
  assign fall = sig_q & ~sig;

endmodule

// File: rtl/ext_prog_mem.sv
// External program-memory responder: latches ALE address, reads ROM,
// drives P0 during the PSEN-low window.
module ext_prog_mem
  import mcu51_bus_pkg::*;
#(
  parameter int              ADDR_W  = ADDR_W_DEF,
  parameter int              DATA_W  = DATA_W_DEF,
  parameter int              TIMEOUT = 15,
  parameter logic [DATA_W-1:0] FILL  = FILL_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ALE,
  input  logic              PSEN,
  input  logic [7:0]        P0_in,
  input  logic [7:0]        P2_in,
  output logic [DATA_W-1:0] P0_out,
  output logic              P0_oe,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_ready,
  output logic              fetch_err,
  output logic [15:0]       fetch_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  bus_state_e        state, state_nxt;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] data_buf, data_buf_nxt;
  logic [TMO_W-1:0]  tmo, tmo_nxt;
  logic              pend, pend_nxt;
  logic              err_set, cnt_inc;
  logic              ale_rise, ale_fall;
  logic              psen_rise, psen_fall;

  bus_edge_det #(.INIT(1'b0)) u_ale (
    .clk  (clk),
    .reset(reset),
    .sig  (ALE),
    .rise (ale_rise),
    .fall (ale_fall)
  );

  bus_edge_det #(.INIT(1'b1)) u_psen (
    .clk  (clk),
    .reset(reset),
    .sig  (PSEN),
    .rise (psen_rise),
    .fall (psen_fall)
  );

  always_comb begin
    state_nxt    = state;
    tmo_nxt      = tmo;
    pend_nxt     = pend;
    data_buf_nxt = data_buf;
    err_set      = 1'b0;
    cnt_inc      = 1'b0;
    rom_rd       = 1'b0;
    // PSEN arrived before the byte: flag it, serve once data lands
    if (state == ST_REQ || state == ST_LOOKUP) begin
      if (psen_fall) begin
        err_set  = 1'b1;
        pend_nxt = 1'b1;
      end else if (psen_rise) begin
        pend_nxt = 1'b0;
      end
    end
    unique case (state)
      ST_IDLE: begin
        if (psen_fall) err_set = 1'b1;
        if (ale_fall)  state_nxt = ST_REQ;
      end
      ST_REQ: begin
        rom_rd    = 1'b1;
        tmo_nxt   = '0;
        state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (rom_ready) begin
          data_buf_nxt = rom_data;
          state_nxt    = pend_nxt ? ST_DRIVE : ST_READY;
        end else if (tmo == TMO_LAST) begin
          data_buf_nxt = FILL;
          err_set      = 1'b1;
          state_nxt    = pend_nxt ? ST_DRIVE : ST_READY;
        end else begin
          tmo_nxt = tmo + 1'b1;
        end
      end
      ST_READY: begin
        if (psen_fall) state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (psen_rise) begin
          cnt_inc   = 1'b1;
          state_nxt = ale_fall ? ST_REQ : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // a new address phase never overlaps a driven P0
    if (ale_rise && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
      cnt_inc   = 1'b0;
    end
    if (state_nxt != ST_REQ && state_nxt != ST_LOOKUP)
      pend_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      P0_out    <= '0;
      P0_oe     <= 1'b0;
      rom_addr  <= '0;
      fetch_err <= 1'b0;
      fetch_cnt <= '0;
      addr_hold <= '0;
      data_buf  <= '0;
      tmo       <= '0;
      pend      <= 1'b0;
    end else begin
      state    <= state_nxt;
      data_buf <= data_buf_nxt;
      tmo      <= tmo_nxt;
      pend     <= pend_nxt;
      P0_oe    <= (state_nxt == ST_DRIVE);
      if (ALE)
        addr_hold <= ADDR_W'({P2_in, P0_in});
      if (state_nxt == ST_REQ && state != ST_REQ)
        rom_addr <= addr_hold;
      if (state_nxt == ST_DRIVE)
        P0_out <= data_buf_nxt;
      if (err_set)
        fetch_err <= 1'b1;
      if (cnt_inc)
        fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ext_prog_mem.sv
// Directed bench for ext_prog_mem: fetch, late ROM, timeout,
// abort, stray PSEN and reset during drive.
module tb_ext_prog_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        ALE;
  logic        PSEN;
  logic [7:0]  P0_in;
  logic [7:0]  P2_in;
  logic [7:0]  P0_out;
  logic        P0_oe;
  logic [15:0] rom_addr;
  logic        rom_rd;
  logic [7:0]  rom_data;
  logic        rom_ready;
  logic        fetch_err;
  logic [15:0] fetch_cnt;

  int pass_cnt = 0;
  int total    = 0;

  ext_prog_mem dut (
    .clk      (clk),
    .reset    (reset),
    .ALE      (ALE),
    .PSEN     (PSEN),
    .P0_in    (P0_in),
    .P2_in    (P2_in),
    .P0_out   (P0_out),
    .P0_oe    (P0_oe),
    .rom_addr (rom_addr),
    .rom_rd   (rom_rd),
    .rom_data (rom_data),
    .rom_ready(rom_ready),
    .fetch_err(fetch_err),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ALE = 1'b0;
    PSEN = 1'b1;
    P0_in = 8'h00;
    P2_in = 8'h00;
    rom_data = 8'h00;
    rom_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // ALE pulse; returns in the cycle where rom_rd is high
  task automatic do_ale(input logic [15:0] a);
    ALE = 1'b1;
    P2_in = a[15:8];
    P0_in = a[7:0];
    tick();
    ALE = 1'b0;
    P2_in = 8'hEE;
    P0_in = 8'hEE;
    tick();
  endtask

  task automatic fetch_to_drive(input logic [15:0] a,
                                input logic [7:0] d);
    do_ale(a);
    tick();
    rom_ready = 1'b1;
    rom_data = d;
    tick();
    rom_ready = 1'b0;
    PSEN = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({P0_oe, rom_rd, fetch_err} !== 3'b000) begin
      $display("FAIL reset_flags got %b want 000",
               {P0_oe, rom_rd, fetch_err});
    end else pass_cnt++;
    total++;
    if ({P0_out, rom_addr, fetch_cnt} !== 40'h0) begin
      $display("FAIL reset_vals got %h want 0",
               {P0_out, rom_addr, fetch_cnt});
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    do_reset();
    do_ale(16'h1234);
    total++;
    if (rom_rd !== 1'b1 || rom_addr !== 16'h1234) begin
      $display("FAIL basic_req got rd=%b addr=%h want 1 1234",
               rom_rd, rom_addr);
    end else pass_cnt++;
    rom_ready = 1'b1;
    rom_data = 8'hA5;
    tick();
    total++;
    if (rom_rd !== 1'b0) begin
      $display("FAIL basic_rd_once got %b want 0", rom_rd);
    end else pass_cnt++;
    tick();
    rom_ready = 1'b0;
    rom_data = 8'h00;
    total++;
    if (P0_oe !== 1'b0) begin
      $display("FAIL basic_ready_oe got %b want 0", P0_oe);
    end else pass_cnt++;
    PSEN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (P0_oe !== 1'b1 || P0_out !== 8'hA5) begin
        $display("FAIL basic_drive%0d got oe=%b d=%h want 1 a5",
                 i, P0_oe, P0_out);
      end else pass_cnt++;
    end
    PSEN = 1'b1;
    tick();
    total++;
    if (P0_oe !== 1'b0 || P0_out !== 8'hA5) begin
      $display("FAIL basic_release got oe=%b d=%h want 0 a5",
               P0_oe, P0_out);
    end else pass_cnt++;
    total++;
    if (fetch_cnt !== 16'd1 || fetch_err !== 1'b0) begin
      $display("FAIL basic_cnt got cnt=%0d err=%b want 1 0",
               fetch_cnt, fetch_err);
    end else pass_cnt++;
  endtask

  task automatic test_late_rom();
    do_reset();
    do_ale(16'h2222);
    tick();
    tick();
    PSEN = 1'b0;
    tick();
    total++;
    if (fetch_err !== 1'b1 || P0_oe !== 1'b0) begin
      $display("FAIL late_err got err=%b oe=%b want 1 0",
               fetch_err, P0_oe);
    end else pass_cnt++;
    tick();
    tick();
    rom_ready = 1'b1;
    rom_data = 8'h5A;
    tick();
    rom_ready = 1'b0;
    total++;
    if (P0_oe !== 1'b1 || P0_out !== 8'h5A) begin
      $display("FAIL late_drive got oe=%b d=%h want 1 5a",
               P0_oe, P0_out);
    end else pass_cnt++;
    PSEN = 1'b1;
    tick();
    total++;
    if (P0_oe !== 1'b0 || fetch_cnt !== 16'd1) begin
      $display("FAIL late_done got oe=%b cnt=%0d want 0 1",
               P0_oe, fetch_cnt);
    end else pass_cnt++;
  endtask

  task automatic test_timeout();
    do_reset();
    do_ale(16'h4321);
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (fetch_err !== 1'b0) begin
      $display("FAIL tmo_early got %b want 0", fetch_err);
    end else pass_cnt++;
    tick();
    total++;
    if (fetch_err !== 1'b1) begin
      $display("FAIL tmo_err got %b want 1", fetch_err);
    end else pass_cnt++;
    PSEN = 1'b0;
    tick();
    total++;
    if (P0_oe !== 1'b1 || P0_out !== 8'hFF) begin
      $display("FAIL tmo_fill got oe=%b d=%h want 1 ff",
               P0_oe, P0_out);
    end else pass_cnt++;
    PSEN = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    fetch_to_drive(16'h0055, 8'h11);
    total++;
    if (P0_oe !== 1'b1) begin
      $display("FAIL abort_pre got %b want 1", P0_oe);
    end else pass_cnt++;
    ALE = 1'b1;
    P2_in = 8'h01;
    P0_in = 8'h00;
    tick();
    total++;
    if (P0_oe !== 1'b0 || fetch_cnt !== 16'd0) begin
      $display("FAIL abort_oe got oe=%b cnt=%0d want 0 0",
               P0_oe, fetch_cnt);
    end else pass_cnt++;
    ALE = 1'b0;
    PSEN = 1'b1;
    tick();
    total++;
    if (rom_rd !== 1'b1 || rom_addr !== 16'h0100) begin
      $display("FAIL abort_new got rd=%b addr=%h want 1 0100",
               rom_rd, rom_addr);
    end else pass_cnt++;
    tick();
    rom_ready = 1'b1;
    rom_data = 8'h22;
    tick();
    rom_ready = 1'b0;
    PSEN = 1'b0;
    tick();
    PSEN = 1'b1;
    tick();
    total++;
    if (fetch_cnt !== 16'd1 || P0_out !== 8'h22) begin
      $display("FAIL abort_next got cnt=%0d d=%h want 1 22",
               fetch_cnt, P0_out);
    end else pass_cnt++;
  endtask

  task automatic test_stray_psen();
    do_reset();
    PSEN = 1'b0;
    tick();
    total++;
    if (P0_oe !== 1'b0 || fetch_err !== 1'b1) begin
      $display("FAIL stray_err got oe=%b err=%b want 0 1",
               P0_oe, fetch_err);
    end else pass_cnt++;
    PSEN = 1'b1;
    tick();
    total++;
    if (P0_oe !== 1'b0 || fetch_cnt !== 16'd0) begin
      $display("FAIL stray_cnt got oe=%b cnt=%0d want 0 0",
               P0_oe, fetch_cnt);
    end else pass_cnt++;
  endtask

  task automatic test_reset_drive();
    do_reset();
    fetch_to_drive(16'h0300, 8'h33);
    PSEN = 1'b1;
    tick();
    fetch_to_drive(16'h0301, 8'h44);
    total++;
    if (P0_oe !== 1'b1 || fetch_cnt !== 16'd1) begin
      $display("FAIL rstdrv_pre got oe=%b cnt=%0d want 1 1",
               P0_oe, fetch_cnt);
    end else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    PSEN = 1'b1;
    total++;
    if (P0_oe !== 1'b0 || fetch_cnt !== 16'd0) begin
      $display("FAIL rstdrv_clr got oe=%b cnt=%0d want 0 0",
               P0_oe, fetch_cnt);
    end else pass_cnt++;
    tick();
    fetch_to_drive(16'h0400, 8'h66);
    total++;
    if (P0_oe !== 1'b1 || P0_out !== 8'h66) begin
      $display("FAIL rstdrv_again got oe=%b d=%h want 1 66",
               P0_oe, P0_out);
    end else pass_cnt++;
    PSEN = 1'b1;
    tick();
    total++;
    if (fetch_cnt !== 16'd1 || fetch_err !== 1'b0) begin
      $display("FAIL rstdrv_cnt got cnt=%0d err=%b want 1 0",
               fetch_cnt, fetch_err);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_late_rom();
    test_timeout();
    test_abort();
    test_stray_psen();
    test_reset_drive();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
